// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;
   typedef enum logic [1:0] {FETCH, WAIT, HALTED} fetch_state_t;
   localparam int PC_INC        = 2;
   localparam int DEF_BUF_DEPTH = 2;
   localparam int DEF_PC_W      = 16;
   localparam int DEF_INST_W    = 16;
endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO holding fetched {pc, instruction} pairs; flush wins over push.
module fetch_buf #(
   parameter int DEPTH = 2,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic          i_flush,
   input  logic [W-1:0]  i_din,
   output logic [CW-1:0] o_count,
   output logic [W-1:0]  o_head
);
   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_pop, w_push;

   // Out-of-range requests are ignored so a misbehaving caller cannot corrupt pointers.
   assign w_pop  = i_pop && (r_cnt != '0);
   assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wp] <= i_din;
   end

   assign o_count = r_cnt;
   assign o_head  = r_mem[r_rp];
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller around the pc register: one outstanding imem request, FIFO to decode.
// Optional misaligned-PC trap enabled by defining FETCH_ALIGN_CHK_EN.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int BUF_DEPTH = DEF_BUF_DEPTH,
   parameter int PC_W      = DEF_PC_W,
   parameter int INST_W    = DEF_INST_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   pc_cur,
   output logic [PC_W-1:0]   pc_next,
   output logic              pc_hold,
   input  logic              redirect_vld,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt,
   output logic              imem_req_vld,
   input  logic              imem_req_rdy,
   output logic [PC_W-1:0]   imem_req_addr,
   input  logic              imem_rsp_vld,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_vld,
   input  logic              inst_rdy,
   output logic [INST_W-1:0] inst_data,
   output logic [PC_W-1:0]   inst_pc,
   output logic              align_err
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;

   fetch_state_t          r_state;
   logic [PC_W-1:0]       r_inflight_pc;
   logic                  r_drop;
   logic                  r_halt_pend;
   logic [CW-1:0]         w_count;
   logic [PC_W+INST_W-1:0] w_head;
   logic                  w_misalign, w_issue, w_accept, w_redir, w_push, w_pop;

`ifdef FETCH_ALIGN_CHK_EN
   logic r_align_err;
   assign w_misalign = pc_cur[0];
   assign align_err  = r_align_err;
`else
   assign w_misalign = 1'b0;
   assign align_err  = 1'b0;
`endif

   // Only FETCH issues, so the in-flight slot is already free whenever count is checked.
   assign w_issue  = (r_state == FETCH) && !halt && !w_misalign && (w_count != CW'(BUF_DEPTH));
   assign imem_req_vld  = rst_n && w_issue;
   assign imem_req_addr = pc_cur;
   assign w_accept = imem_req_vld && imem_req_rdy;
   assign w_redir  = rst_n && redirect_vld && (r_state != HALTED);

   assign pc_next = w_redir  ? redirect_pc :
                    w_accept ? pc_cur + PC_W'(PC_INC) : pc_cur;
   assign pc_hold = !(w_redir || w_accept);

   assign w_push   = (r_state == WAIT) && imem_rsp_vld && !r_drop && !w_redir;
   assign inst_vld = (w_count != '0);
   assign w_pop    = inst_vld && inst_rdy;

   fetch_buf #(.DEPTH(BUF_DEPTH), .W(PC_W + INST_W)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_redir),
      .i_din   ({r_inflight_pc, imem_rsp_data}),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign inst_pc   = w_head[PC_W+INST_W-1:INST_W];
   assign inst_data = w_head[INST_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= FETCH;
         r_inflight_pc <= '0;
         r_drop        <= 1'b0;
         r_halt_pend   <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
         r_align_err   <= 1'b0;
`endif
      end else begin
         case (r_state)
            FETCH: begin
               if (w_misalign) begin
`ifdef FETCH_ALIGN_CHK_EN
                  r_align_err <= 1'b1;
`endif
                  r_state <= HALTED;
               end else if (halt) begin
                  r_state <= HALTED;
               end else if (w_accept) begin
                  r_inflight_pc <= pc_cur;
                  r_drop        <= w_redir;
                  r_state       <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_vld) begin
                  r_drop      <= 1'b0;
                  r_halt_pend <= 1'b0;
                  r_state     <= (halt || r_halt_pend) ? HALTED : FETCH;
               end else begin
                  if (halt)    r_halt_pend <= 1'b1;
                  if (w_redir) r_drop      <= 1'b1;
               end
            end
            default: r_state <= HALTED;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the pc register and a simple imem responder.
module tb_fetch_ctrl;
   logic        clk, rst_n;
   logic [15:0] pc_cur, pc_next, redirect_pc, imem_req_addr, imem_rsp_data, inst_data, inst_pc;
   logic        pc_hold, redirect_vld, halt, imem_req_vld, imem_req_rdy, imem_rsp_vld;
   logic        inst_vld, inst_rdy, align_err;
   logic        auto_rsp;
   int          n_chk, n_pass;

   fetch_ctrl #(.BUF_DEPTH(2), .PC_W(16), .INST_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next), .pc_hold(pc_hold),
      .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .halt(halt),
      .imem_req_vld(imem_req_vld), .imem_req_rdy(imem_req_rdy), .imem_req_addr(imem_req_addr),
      .imem_rsp_vld(imem_rsp_vld), .imem_rsp_data(imem_rsp_data),
      .inst_vld(inst_vld), .inst_rdy(inst_rdy), .inst_data(inst_data), .inst_pc(inst_pc),
      .align_err(align_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // pc register the controller drives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pc_cur <= 16'h0000;
      else if (!pc_hold) pc_cur <= pc_next;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // One clock; a request accepted this cycle is answered next cycle when auto_rsp is set.
   task automatic step();
      logic        acc;
      logic [15:0] a;
      @(negedge clk);
      acc = imem_req_vld && imem_req_rdy;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      redirect_vld  = 1'b0;
      halt          = 1'b0;
      imem_rsp_vld  = auto_rsp && acc;
      imem_rsp_data = a ^ 16'h5A00;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_vld = 1'b0; redirect_pc = '0; halt = 1'b0;
      imem_req_rdy = 1'b1; imem_rsp_vld = 1'b0; imem_rsp_data = '0;
      inst_rdy = 1'b0; auto_rsp = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_vld", imem_req_vld, 0);
      chk("rst_pc_hold", pc_hold, 1);
      chk("rst_inst_vld", inst_vld, 0);
      chk("rst_align_err", align_err, 0);
      rst_n = 1'b1;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      n_chk = 0; n_pass = 0;

      // streaming fetch, 1-cycle memory, decode always ready
      do_reset();
      inst_rdy = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("seq_req_vld", imem_req_vld, 1);
         chk("seq_addr", imem_req_addr, 16'(2*i));
         chk("seq_hold_acc", pc_hold, 0);
         chk("seq_pc_next", pc_next, 16'(2*i+2));
         step();
         chk("seq_wait_req", imem_req_vld, 0);
         chk("seq_wait_hold", pc_hold, 1);
         step();
         chk("seq_inst_vld", inst_vld, 1);
         chk("seq_inst_pc", inst_pc, 16'(2*i));
         chk("seq_inst_data", inst_data, 16'(2*i) ^ 16'h5A00);
      end

      // back-pressure: FIFO of 2 fills, then issue stops until a pop
      do_reset();
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (imem_req_vld && imem_req_rdy) n++;
         step();
      end
      chk("bp_num_req", n, 2);
      chk("bp_req_vld", imem_req_vld, 0);
      chk("bp_hold", pc_hold, 1);
      chk("bp_head_pc", inst_pc, 16'h0000);
      inst_rdy = 1'b1;
      #1;
      step();
      inst_rdy = 1'b0;
      #1;
      chk("bp_resume_req", imem_req_vld, 1);
      chk("bp_resume_addr", imem_req_addr, 16'h0004);

      // redirect during WAIT: FIFO flushed, stale response dropped
      do_reset();
      step();
      step();
      chk("rw_pre_inst_vld", inst_vld, 1);
      auto_rsp = 1'b0;
      step();
      redirect_vld = 1'b1; redirect_pc = 16'h0100;
      #1;
      chk("rw_hold", pc_hold, 0);
      chk("rw_pc_next", pc_next, 16'h0100);
      step();
      imem_rsp_vld = 1'b1; imem_rsp_data = 16'h1234;
      #1;
      chk("rw_flushed", inst_vld, 0);
      chk("rw_wait_req", imem_req_vld, 0);
      step();
      chk("rw_dropped", inst_vld, 0);
      chk("rw_req_vld", imem_req_vld, 1);
      chk("rw_addr", imem_req_addr, 16'h0100);

      // redirect with same-cycle response, then with same-cycle accept
      do_reset();
      auto_rsp = 1'b0;
      step();
      imem_rsp_vld = 1'b1; imem_rsp_data = 16'hBEEF;
      redirect_vld = 1'b1; redirect_pc = 16'h0200;
      #1;
      step();
      chk("rr_not_pushed", inst_vld, 0);
      chk("rr_req_vld", imem_req_vld, 1);
      chk("rr_addr", imem_req_addr, 16'h0200);
      auto_rsp = 1'b1;
      step();
      step();
      chk("rr_inst_vld", inst_vld, 1);
      chk("rr_inst_pc", inst_pc, 16'h0200);
      chk("rr_inst_data", inst_data, 16'h5800);
      chk("ra_addr", imem_req_addr, 16'h0202);
      redirect_vld = 1'b1; redirect_pc = 16'h0300;
      #1;
      chk("ra_pc_next", pc_next, 16'h0300);
      chk("ra_req_vld", imem_req_vld, 1);
      step();
      chk("ra_flushed", inst_vld, 0);
      chk("ra_wait_req", imem_req_vld, 0);
      step();
      chk("ra_dropped", inst_vld, 0);
      chk("ra_req_vld2", imem_req_vld, 1);
      chk("ra_addr2", imem_req_addr, 16'h0300);

      // halt while waiting: response still pushed, then stopped for good
      do_reset();
      step();
      halt = 1'b1;
      #1;
      chk("h_wait_req", imem_req_vld, 0);
      step();
      chk("h_inst_vld", inst_vld, 1);
      chk("h_inst_pc", inst_pc, 16'h0000);
      chk("h_req_vld", imem_req_vld, 0);
      chk("h_hold", pc_hold, 1);
      redirect_vld = 1'b1; redirect_pc = 16'h0400;
      #1;
      chk("h_redir_hold", pc_hold, 1);
      step();
      chk("h_req_vld2", imem_req_vld, 0);
      inst_rdy = 1'b1;
      #1;
      step();
      chk("h_drained", inst_vld, 0);
      chk("h_req_vld3", imem_req_vld, 0);
      do_reset();
      chk("h_resume_req", imem_req_vld, 1);
      chk("h_resume_addr", imem_req_addr, 16'h0000);

      // pc wrap at top of the address space
      do_reset();
      imem_req_rdy = 1'b0;
      redirect_vld = 1'b1; redirect_pc = 16'hFFFE;
      #1;
      step();
      imem_req_rdy = 1'b1;
      #1;
      chk("wr_addr", imem_req_addr, 16'hFFFE);
      chk("wr_pc_next", pc_next, 16'h0000);
      chk("wr_hold", pc_hold, 0);
      step();
      step();
      chk("wr_inst_pc", inst_pc, 16'hFFFE);
      chk("wr_inst_data", inst_data, 16'hA5FE);
      chk("wr_next_addr", imem_req_addr, 16'h0000);

      // misaligned pc
      do_reset();
      imem_req_rdy = 1'b0;
      redirect_vld = 1'b1; redirect_pc = 16'h0003;
      #1;
      step();
      imem_req_rdy = 1'b1;
      #1;
`ifdef FETCH_ALIGN_CHK_EN
      chk("al_no_req", imem_req_vld, 0);
      step();
      chk("al_err", align_err, 1);
      chk("al_halted_req", imem_req_vld, 0);
`else
      chk("al_req_passed", imem_req_vld, 1);
      chk("al_addr", imem_req_addr, 16'h0003);
      step();
      chk("al_err_tied", align_err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
